// File: rtl/preempt_timer_bank.sv
`default_nettype none
// ============================================================================
// Module      : preempt_timer_bank
// Description : Bank of CHANNELS independent WIDTH-bit preemption down-counters.
//               Each channel is one-shot or periodic and raises a pending bit
//               on expiry. The pending bits are priority-encoded onto a single
//               interrupt line with an acknowledge handshake. A global pause
//               freezes every counter. All state changes on the falling edge.
// Ports       : i_clock / i_reset          - clock (falling edge), async reset
//               i_load, i_load_ch, i_load_value, i_load_periodic - load a channel
//               i_stop, i_stop_ch          - stop a channel
//               i_force, i_force_ch        - force-expire an active channel
//               i_pause                    - freeze all counters
//               i_irq_ack                  - acknowledge channel on o_irq_ch
//               o_irq, o_irq_ch            - interrupt and lowest pending channel
//               o_active, o_pending, o_overrun - per-channel status flags
//               i_read_ch, o_read_count    - count readback
// Revision    : 1.0 - initial release
// ============================================================================
module preempt_timer_bank #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 4,
    parameter int CH_BITS  = 2
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                i_load,
    input  logic [CH_BITS-1:0]  i_load_ch,
    input  logic [WIDTH-1:0]    i_load_value,
    input  logic                i_load_periodic,
    input  logic                i_stop,
    input  logic [CH_BITS-1:0]  i_stop_ch,
    input  logic                i_force,
    input  logic [CH_BITS-1:0]  i_force_ch,
    input  logic                i_pause,
    input  logic                i_irq_ack,
    output logic                o_irq,
    output logic [CH_BITS-1:0]  o_irq_ch,
    output logic [CHANNELS-1:0] o_active,
    output logic [CHANNELS-1:0] o_pending,
    output logic [CHANNELS-1:0] o_overrun,
    input  logic [CH_BITS-1:0]  i_read_ch,
    output logic [WIDTH-1:0]    o_read_count
);

    logic [WIDTH-1:0]    r_count  [CHANNELS];
    logic [WIDTH-1:0]    r_reload [CHANNELS];
    logic [CHANNELS-1:0] r_periodic;
    logic [CHANNELS-1:0] r_active;
    logic [CHANNELS-1:0] r_pending;
    logic [CHANNELS-1:0] r_overrun;
    logic                r_irq;

    logic [WIDTH-1:0]    w_count_nxt  [CHANNELS];
    logic [WIDTH-1:0]    w_reload_nxt [CHANNELS];
    logic [CHANNELS-1:0] w_periodic_nxt;
    logic [CHANNELS-1:0] w_active_nxt;
    logic [CHANNELS-1:0] w_pending_nxt;
    logic [CHANNELS-1:0] w_overrun_nxt;

    logic [CHANNELS-1:0] w_stop_hit;
    logic [CHANNELS-1:0] w_load_hit;
    logic [CHANNELS-1:0] w_ack_hit;
    logic [CHANNELS-1:0] w_expire;
    logic [CH_BITS-1:0]  w_irq_ch;
    logic [WIDTH-1:0]    w_read_count;
    logic                w_ack_valid;

    // Lowest-index pending channel wins; scanning downward lets the lowest
    // match overwrite the others.
    always_comb begin
        w_irq_ch = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (r_pending[i]) begin
                w_irq_ch = CH_BITS'(i);
            end
        end
    end

    // Out-of-range indices match no channel and read back 0.
    always_comb begin
        w_read_count = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (i_read_ch == CH_BITS'(i)) begin
                w_read_count = r_count[i];
            end
        end
    end

    // An acknowledge only counts while the interrupt line is actually raised.
    assign w_ack_valid = i_irq_ack & r_irq;

    always_comb begin
        w_stop_hit = '0;
        w_load_hit = '0;
        w_ack_hit  = '0;
        w_expire   = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            w_stop_hit[i] = i_stop & (i_stop_ch == CH_BITS'(i));
            w_load_hit[i] = i_load & (i_load_ch == CH_BITS'(i));
            w_ack_hit[i]  = w_ack_valid & (w_irq_ch == CH_BITS'(i));
            // Force ignores pause and count; a tick expiry needs count == 0.
            w_expire[i]   = r_active[i] &
                            ((i_force & (i_force_ch == CH_BITS'(i))) |
                             (~i_pause & (r_count[i] == '0)));
        end
    end

    // Per-channel next state. Stop outranks load, load outranks any expiry.
    always_comb begin
        w_count_nxt    = r_count;
        w_reload_nxt   = r_reload;
        w_periodic_nxt = r_periodic;
        w_active_nxt   = r_active;
        w_pending_nxt  = r_pending;
        w_overrun_nxt  = r_overrun;
        for (int i = 0; i < CHANNELS; i++) begin
            if (w_stop_hit[i]) begin
                w_active_nxt[i]  = 1'b0;
                w_pending_nxt[i] = 1'b0;
                w_overrun_nxt[i] = 1'b0;
            end else if (w_load_hit[i]) begin
                w_count_nxt[i]    = i_load_value;
                w_reload_nxt[i]   = i_load_value;
                w_periodic_nxt[i] = i_load_periodic;
                w_active_nxt[i]   = (i_load_value != '0);
                w_pending_nxt[i]  = 1'b0;
                w_overrun_nxt[i]  = 1'b0;
            end else begin
                if (w_ack_hit[i]) begin
                    w_pending_nxt[i] = 1'b0;
                    w_overrun_nxt[i] = 1'b0;
                end
                if (w_expire[i]) begin
                    // A same-cycle ack consumes the old pending, so no overrun.
                    if (r_pending[i] && !w_ack_hit[i]) begin
                        w_overrun_nxt[i] = 1'b1;
                    end
                    w_pending_nxt[i] = 1'b1;
                    if (r_periodic[i]) begin
                        w_count_nxt[i] = r_reload[i];
                    end else begin
                        w_active_nxt[i] = 1'b0;
                    end
                end else if (r_active[i] && !i_pause) begin
                    // count is nonzero here, otherwise the channel expired.
                    w_count_nxt[i] = r_count[i] - WIDTH'(1);
                end
            end
        end
    end

    always_ff @(negedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_count[i]  <= '0;
                r_reload[i] <= '0;
            end
            r_periodic <= '0;
            r_active   <= '0;
            r_pending  <= '0;
            r_overrun  <= '0;
            r_irq      <= 1'b0;
        end else begin
            r_count    <= w_count_nxt;
            r_reload   <= w_reload_nxt;
            r_periodic <= w_periodic_nxt;
            r_active   <= w_active_nxt;
            r_pending  <= w_pending_nxt;
            r_overrun  <= w_overrun_nxt;
            r_irq      <= |w_pending_nxt;
        end
    end

    assign o_irq        = r_irq;
    assign o_irq_ch     = w_irq_ch;
    assign o_active     = r_active;
    assign o_pending    = r_pending;
    assign o_overrun    = r_overrun;
    assign o_read_count = w_read_count;

endmodule
`default_nettype wire

// File: tb/tb_preempt_timer_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_preempt_timer_bank
// Description : Self-checking bench for preempt_timer_bank: directed scenarios
//               plus randomized traffic, all compared against a behavioural
//               per-channel timer model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_preempt_timer_bank;

    localparam int c_W  = 32;
    localparam int c_N  = 4;
    localparam int c_CB = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            ld = 1'b0, ld_per = 1'b0, st = 1'b0, fc = 1'b0;
    logic            pause = 1'b0, ack = 1'b0;
    logic [c_CB-1:0] ld_ch = '0, st_ch = '0, fc_ch = '0, rd_ch = '0;
    logic [c_W-1:0]  ld_val = '0;
    logic            irq;
    logic [c_CB-1:0] irq_ch;
    logic [c_N-1:0]  active, pending, overrun;
    logic [c_W-1:0]  read_count;

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model state: one record of timer facts per channel.
    longint unsigned m_remaining [c_N];
    longint unsigned m_quantum   [c_N];
    bit              m_periodic  [c_N];
    bit              m_running   [c_N];
    bit              m_pend      [c_N];
    bit              m_ovr       [c_N];

    preempt_timer_bank #(.WIDTH(c_W), .CHANNELS(c_N), .CH_BITS(c_CB)) dut (
        .i_clock(clk), .i_reset(rst),
        .i_load(ld), .i_load_ch(ld_ch), .i_load_value(ld_val), .i_load_periodic(ld_per),
        .i_stop(st), .i_stop_ch(st_ch),
        .i_force(fc), .i_force_ch(fc_ch),
        .i_pause(pause), .i_irq_ack(ack),
        .o_irq(irq), .o_irq_ch(irq_ch),
        .o_active(active), .o_pending(pending), .o_overrun(overrun),
        .i_read_ch(rd_ch), .o_read_count(read_count)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit m_any_pending();
        for (int c = 0; c < c_N; c++) if (m_pend[c]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int m_first_pending();
        for (int c = 0; c < c_N; c++) if (m_pend[c]) return c;
        return 0;
    endfunction

    function automatic logic [c_N-1:0] m_vec(input int which);
        logic [c_N-1:0] v;
        v = '0;
        for (int c = 0; c < c_N; c++)
            v[c] = (which == 0) ? m_running[c] : (which == 1) ? m_pend[c] : m_ovr[c];
        return v;
    endfunction

    task automatic m_clear();
        for (int c = 0; c < c_N; c++) begin
            m_remaining[c] = 0; m_quantum[c] = 0; m_periodic[c] = 0;
            m_running[c] = 0; m_pend[c] = 0; m_ovr[c] = 0;
        end
    endtask

    // One falling edge of the timer, using inputs and model state before it.
    task automatic m_edge();
        bit ack_ok;
        int target;
        ack_ok = ack && m_any_pending();
        target = m_first_pending();
        for (int c = 0; c < c_N; c++) begin
            bit was_pend, acked, fires;
            was_pend = m_pend[c];
            acked    = ack_ok && (target == c);
            fires    = m_running[c] &&
                       ((fc && fc_ch == c) || (!pause && m_remaining[c] == 0));
            if (st && st_ch == c) begin
                m_running[c] = 0; m_pend[c] = 0; m_ovr[c] = 0;
            end else if (ld && ld_ch == c) begin
                m_remaining[c] = ld_val; m_quantum[c] = ld_val;
                m_periodic[c] = ld_per; m_running[c] = (ld_val != 0);
                m_pend[c] = 0; m_ovr[c] = 0;
            end else begin
                if (acked) begin m_pend[c] = 0; m_ovr[c] = 0; end
                if (fires) begin
                    m_ovr[c]  = m_ovr[c] | (was_pend & ~acked);
                    m_pend[c] = 1;
                    if (m_periodic[c]) m_remaining[c] = m_quantum[c];
                    else               m_running[c]   = 0;
                end else if (m_running[c] && !pause) begin
                    m_remaining[c] = m_remaining[c] - 1;
                end
            end
        end
    endtask

    task automatic compare_all();
        check_val("irq",     irq,     m_any_pending());
        check_val("irq_ch",  irq_ch,  m_any_pending() ? m_first_pending() : 0);
        check_val("active",  active,  m_vec(0));
        check_val("pending", pending, m_vec(1));
        check_val("overrun", overrun, m_vec(2));
        check_val("read_count", read_count, m_remaining[rd_ch]);
    endtask

    task automatic step();
        @(negedge clk);
        m_edge();
        #1;
        compare_all();
        ld = 0; st = 0; fc = 0; ack = 0;
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    // Asynchronous reset applied between edges; outputs must clear at once.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        m_clear();
        compare_all();
        check_val("rst_irq", irq, 1'b0);
        check_val("rst_flags", {active, pending, overrun}, '0);
        #1;
        rst = 1'b0;
    endtask

    task automatic load(input int ch, input int val, input bit per);
        ld = 1; ld_ch = c_CB'(ch); ld_val = c_W'(val); ld_per = per;
    endtask

    initial begin
        m_clear();
        @(posedge clk);
        do_reset();

        // One-shot ch1 with 5: expiry on the 6th edge after the load edge.
        load(1, 5, 0); step();
        steps(5);
        check_val("os_early", irq, 1'b0);
        step();
        check_val("os_irq", irq, 1'b1);
        check_val("os_ch", irq_ch, 2'd1);
        check_val("os_act", active[1], 1'b0);
        ack = 1; step();
        check_val("os_ack", irq, 1'b0);

        // Periodic ch0 with 3, three paused cycles: expiries at edges 7 and 11.
        do_reset();
        load(0, 3, 1); step();
        step();
        pause = 1; steps(3); pause = 0;
        steps(2);
        check_val("per_e6", pending[0], 1'b0);
        step();
        check_val("per_e7", pending[0], 1'b1);
        check_val("per_act", active[0], 1'b1);
        ack = 1; step();
        steps(2);
        check_val("per_e10", pending[0], 1'b0);
        step();
        check_val("per_e11", pending[0], 1'b1);

        // ch2 and ch3 expiring on the same edge.
        do_reset();
        load(2, 3, 0); step();
        load(3, 2, 0); step();
        steps(3);
        check_val("sim_ch2", irq_ch, 2'd2);
        ack = 1; step();
        check_val("sim_ch3", irq_ch, 2'd3);
        check_val("sim_irq", irq, 1'b1);
        ack = 1; step();
        check_val("sim_done", irq, 1'b0);

        // Periodic ch0 with 1, never acked until overrun.
        do_reset();
        load(0, 1, 1); step();
        steps(4);
        check_val("ovr_set", overrun[0], 1'b1);
        ack = 1; step();
        check_val("ovr_clr", {pending[0], overrun[0]}, 2'b00);

        // Force on active/inactive channels, load of zero.
        do_reset();
        load(1, 100, 0); step();
        fc = 1; fc_ch = 2'd1; step();
        check_val("force_act", pending[1], 1'b1);
        fc = 1; fc_ch = 2'd2; step();
        check_val("force_inact", pending[2], 1'b0);
        load(3, 0, 1); step();
        check_val("zero_act", active[3], 1'b0);

        // Reset mid-count, then nothing fires.
        do_reset();
        load(0, 4, 0); step();
        steps(2);
        do_reset();
        steps(8);
        check_val("post_rst_irq", irq, 1'b0);

        // Randomized traffic against the model.
        do_reset();
        for (int n = 0; n < 600; n++) begin
            ld     = ($urandom_range(0, 5) == 0);
            ld_ch  = c_CB'($urandom_range(0, c_N - 1));
            ld_val = c_W'($urandom_range(0, 9));
            ld_per = $urandom_range(0, 1);
            st     = ($urandom_range(0, 15) == 0);
            st_ch  = c_CB'($urandom_range(0, c_N - 1));
            fc     = ($urandom_range(0, 9) == 0);
            fc_ch  = c_CB'($urandom_range(0, c_N - 1));
            pause  = ($urandom_range(0, 4) == 0);
            ack    = ($urandom_range(0, 2) == 0);
            rd_ch  = c_CB'($urandom_range(0, c_N - 1));
            step();
        end
        pause = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/preempt_timer_bank.md
# preempt_timer_bank

Multi-channel preemption timer for the MIPS system, the parametrised successor of the single-quantum scheduler timer. It holds `CHANNELS` independent down-counters of `WIDTH` bits. Each counter is one-shot or periodic, and each raises a pending interrupt bit on expiry. A single priority-encoded interrupt line with an acknowledge handshake goes to the control unit. A global pause input holds every channel while the core is in halt or I/O or instruction-memory-offset phases.

## Interface
Parameters:
- `WIDTH`, 32: counter and quantum width in bits.
- `CHANNELS`, 4: number of timer channels, 1..16.
- `CH_BITS`, 2: channel index width, equal to clog2(`CHANNELS`), minimum 1.

Ports:
- `clock` in 1: system clock. All state updates on the falling edge.
- `reset` in 1: asynchronous, active-high. Clears all state.
- `load` in 1: load strobe for channel `load_ch`.
- `load_ch` in `CH_BITS`: target channel for load.
- `load_value` in `WIDTH`: quantum to load. 0 means disable the channel.
- `load_periodic` in 1: 1 selects auto-reload, 0 selects one-shot.
- `stop` in 1: stop strobe for channel `stop_ch`.
- `stop_ch` in `CH_BITS`: target channel for stop.
- `force` in 1: force-expire strobe for channel `force_ch` (process finish).
- `force_ch` in `CH_BITS`: target channel for force.
- `pause` in 1: freeze all counters (halt, input, output, IM offset).
- `irq_ack` in 1: acknowledge of the channel currently on `irq_ch`.
- `irq` out 1: registered. High while any pending bit is set.
- `irq_ch` out `CH_BITS`: combinational. Lowest-index pending channel, 0 when none.
- `active` out `CHANNELS`: per-channel running flag.
- `pending` out `CHANNELS`: per-channel pending-interrupt flag.
- `overrun` out `CHANNELS`: sticky flag. An expiry occurred while pending was already set.
- `read_ch` in `CH_BITS`: channel select for `read_count`.
- `read_count` out `WIDTH`: combinational. Current count of `read_ch`.

## Operation
Per-channel state: `count[WIDTH]`, `reload[WIDTH]`, `periodic`, `active`, `pending`, `overrun`. All of these reset to 0, and every output is 0 after reset.

Load:
- `count` and `reload` take `load_value`; `periodic` takes `load_periodic`.
- `active` becomes (`load_value` != 0).
- `pending` and `overrun` of that channel are cleared.

Stop: `active`, `pending` and `overrun` of that channel are cleared. `count` is held.

Tick, for an active channel with `pause` = 0:
- If `count` != 0, decrement `count`.
- If `count` == 0, the channel expires.

Expiry:
- `pending` is set. If `pending` was already set and not acknowledged this cycle, `overrun` is set.
- Periodic: `count` reloads from `reload` and `active` stays 1.
- One-shot: `active` becomes 0.

Force:
- On an active channel, force behaves as an immediate expiry regardless of `count` or `pause`.
- On an inactive channel, force is ignored.

Pause:
- No decrements and no tick-driven expiries occur.
- Load, stop, force and ack still act.

Acknowledge: `irq_ack` clears `pending` and `overrun` of the channel on `irq_ch`. It has no effect when `irq` = 0.

Priority for the same channel in the same cycle, highest first: stop, load, force, tick.
- Stop together with load: the channel ends up stopped.
- Load together with expiry: the load wins and no pending is set.

Ack and expiry on the same channel in the same cycle: `pending` stays 1 and `overrun` is not set.

Out-of-range channel indices (≥ `CHANNELS`) are ignored.

Arithmetic is unsigned `WIDTH` bits. The decrement never wraps because expiry occurs at 0.

## Timing
- Loading value N with no pause: the expiry edge is the (N+1)th falling edge after the load edge. `pending` and `irq` are visible after that edge.
- A periodic channel expires every N+1 unpaused cycles.
- Each paused cycle extends the period by exactly one cycle.
- `irq` falls on the ack edge when no other channel is pending. Otherwise `irq` stays high and `irq_ch` moves to the next pending index in the same cycle.
- Reset asserted mid-count: all channels drop out immediately and `irq` goes to 0 asynchronously.

## Test plan
- Load ch1 with 5, one-shot: `irq` rises after the 6th falling edge and `irq_ch` = 1. `active[1]` = 0. Ack clears `irq`.
- Load ch0 with 3, periodic, 3 paused cycles inserted mid-count: first expiry at edge 7, next at edge 11. `active[0]` stays 1.
- Load ch2 and ch3 to expire on the same edge: `irq_ch` = 2. After ack, `irq_ch` = 3 with `irq` still 1. Second ack drops `irq`.
- Periodic ch0 with value 1, ack never asserted: `overrun[0]` = 1 after the second expiry. Ack clears both `pending[0]` and `overrun[0]`.
- Force on active ch1 (count 100): `pending[1]` on the next edge. Force on inactive ch2: no change. Load value 0: `active` stays 0 and no irq.
- Load ch0 with 4, reset asserted mid-count between edges: all outputs 0 immediately. No irq after reset is released.
